// File: rtl/ghost_dir_picker_if.sv
// Request/response bundle between ghost movement logic, the LFSR source and the
// direction picker.
interface ghost_dir_picker_if #(
    parameter int RAND_W = 5
) ();
    logic              req;
    logic [1:0]        cur_dir;
    logic [3:0]        blocked;
    logic [RAND_W-1:0] rand_in;
    logic [1:0]        dir;
    logic              valid;
    logic              busy;
    logic              forced;

    modport master (
        output req, cur_dir, blocked, rand_in,
        input  dir, valid, busy, forced
    );

    modport slave (
        input  req, cur_dir, blocked, rand_in,
        output dir, valid, busy, forced
    );
endinterface

// File: rtl/ghost_dir_picker.sv
// Picks a legal ghost direction by rejection-sampling the LFSR, with a
// deterministic fallback once MAX_TRIES draws have been rejected.
module ghost_dir_picker #(
    parameter int RAND_W    = 5,
    parameter int MAX_TRIES = 8
) (
    input logic               clk,
    input logic               reset_n,
    ghost_dir_picker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAMPLE, FALLBACK, DONE} state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic       forced_q, forced_d;
    logic [3:0] tries_q, tries_d;
    logic [1:0] cur_q, cur_d;
    logic [3:0] blk_q, blk_d;

    logic [1:0] rev;
    logic [3:0] allowed;
    logic [1:0] cand;
    logic [1:0] fb_dir;

    // Legality is judged only against the inputs captured at request time.
    assign rev     = cur_q ^ 2'b10;
    assign allowed = ~blk_q & ~(4'b0001 << rev);
    assign cand    = bus.rand_in[1:0];

    always_comb begin
        fb_dir = cur_q;
        if (allowed[0])      fb_dir = 2'd0;
        else if (allowed[1]) fb_dir = 2'd1;
        else if (allowed[2]) fb_dir = 2'd2;
        else if (allowed[3]) fb_dir = 2'd3;
        else if (!blk_q[rev]) fb_dir = rev;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 2'd0;
            forced_q <= 1'b0;
            tries_q  <= 4'd0;
            cur_q    <= 2'd0;
            blk_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            forced_q <= forced_d;
            tries_q  <= tries_d;
            cur_q    <= cur_d;
            blk_q    <= blk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        forced_d = forced_q;
        tries_d  = tries_q;
        cur_d    = cur_q;
        blk_d    = blk_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cur_d   = bus.cur_dir;
                    blk_d   = bus.blocked;
                    tries_d = 4'd0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (allowed == 4'd0) begin
                    state_d = FALLBACK;
                end else if (allowed[cand]) begin
                    dir_d    = cand;
                    forced_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    tries_d = tries_q + 4'd1;
                    if (tries_q + 4'd1 == MAX_T) state_d = FALLBACK;
                end
            end
            FALLBACK: begin
                dir_d    = fb_dir;
                forced_d = 1'b1;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.dir    = dir_q;
    assign bus.valid  = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);
    assign bus.forced = forced_q;
endmodule

// File: tb/tb_ghost_dir_picker.sv
// Directed bench for ghost_dir_picker: latency, rejection, fallback, reset and
// request-handling cases with hand-computed results.
module tb_ghost_dir_picker;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    ghost_dir_picker_if #(.RAND_W(5)) bus ();

    ghost_dir_picker #(.RAND_W(5), .MAX_TRIES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise req in the current (negedge) slot; the next posedge latches it.
    task automatic start_req(input logic [1:0] cur, input logic [3:0] blk);
        bus.req     = 1'b1;
        bus.cur_dir = cur;
        bus.blocked = blk;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req = 1'b0; bus.cur_dir = 2'd2; bus.blocked = 4'd0; bus.rand_in = 5'b10111;
        repeat (2) @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.forced !== 1'b0) begin errors++; $display("FAIL reset_forced got=%b exp=0", bus.forced); end
        checks++; if (bus.dir !== 2'd0) begin errors++; $display("FAIL reset_dir got=%0d exp=0", bus.dir); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // cur=0, open maze, first draw 1 accepted -> valid at N+2
    task automatic test_direct_accept();
        start_req(2'd0, 4'b0000);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (k == 1) begin
                checks++; if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin errors++; $display("FAIL accept_sample busy=%b valid=%b exp busy=1 valid=0", bus.busy, bus.valid); end
                bus.rand_in = 5'b11001;
            end
        end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL accept_valid got=%b exp=1", bus.valid); end
        checks++; if (bus.dir !== 2'd1 || bus.forced !== 1'b0) begin errors++; $display("FAIL accept_dir dir=%0d forced=%b exp dir=1 forced=0", bus.dir, bus.forced); end
        @(negedge clk);
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL accept_idle valid=%b busy=%b exp 0 0", bus.valid, bus.busy); end
    endtask

    // cur=1: draws 3,3 are the reverse, 0 accepted -> valid N+4; late cur/req changes ignored
    task automatic test_reject_reverse();
        logic [1:0] seq [3];
        int vld_at;
        seq = '{2'd3, 2'd3, 2'd0};
        vld_at = 0;
        start_req(2'd1, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.valid === 1'b1 && vld_at == 0) vld_at = k;
            if (k == 2) begin bus.cur_dir = 2'd3; bus.req = 1'b1; end
            if (k <= 3) bus.rand_in = {3'b010, seq[k-1]};
        end
        checks++; if (vld_at != 4) begin errors++; $display("FAIL reverse_latency got=N+%0d exp=N+4", vld_at); end
        checks++; if (bus.dir !== 2'd0 || bus.forced !== 1'b0) begin errors++; $display("FAIL reverse_dir dir=%0d forced=%b exp dir=0 forced=0", bus.dir, bus.forced); end
        bus.cur_dir = 2'd0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reverse_busy_after got=%b exp=0", bus.busy); end
    endtask

    // blocked=1011, cur=0: nothing allowed -> immediate fallback to unblocked reverse 2
    task automatic test_fallback_reverse();
        int vld_at;
        vld_at = 0;
        start_req(2'd0, 4'b1011);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            bus.rand_in = 5'b00000;
            if (bus.valid === 1'b1 && vld_at == 0) vld_at = k;
        end
        checks++; if (vld_at != 3) begin errors++; $display("FAIL fbrev_latency got=N+%0d exp=N+3", vld_at); end
        checks++; if (bus.dir !== 2'd2 || bus.forced !== 1'b1) begin errors++; $display("FAIL fbrev_dir dir=%0d forced=%b exp dir=2 forced=1", bus.dir, bus.forced); end
        @(negedge clk);
    endtask

    // fully walled, cur=3: hold the current heading
    task automatic test_fallback_hold();
        int vld_at;
        vld_at = 0;
        start_req(2'd3, 4'b1111);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            bus.rand_in = 5'b11110;
            if (bus.valid === 1'b1 && vld_at == 0) vld_at = k;
        end
        checks++; if (vld_at != 3) begin errors++; $display("FAIL fbhold_latency got=N+%0d exp=N+3", vld_at); end
        checks++; if (bus.dir !== 2'd3 || bus.forced !== 1'b1) begin errors++; $display("FAIL fbhold_dir dir=%0d forced=%b exp dir=3 forced=1", bus.dir, bus.forced); end
        @(negedge clk);
    endtask

    // blocked=0110, cur=0: allowed=1001, draws 1/2 always rejected -> fallback picks 0 at N+10
    task automatic test_max_tries();
        int vld_at;
        vld_at = 0;
        start_req(2'd0, 4'b0110);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            bus.rand_in = (k % 2 == 1) ? 5'b10101 : 5'b01110;
            if (bus.valid === 1'b1 && vld_at == 0) vld_at = k;
        end
        checks++; if (vld_at != 10) begin errors++; $display("FAIL maxtries_latency got=N+%0d exp=N+10", vld_at); end
        checks++; if (bus.dir !== 2'd0 || bus.forced !== 1'b1) begin errors++; $display("FAIL maxtries_dir dir=%0d forced=%b exp dir=0 forced=1", bus.dir, bus.forced); end
        @(negedge clk);
    endtask

    // reset mid-SAMPLE: back to idle with reset outputs, no stray valid afterwards
    task automatic test_reset_in_sample();
        int stray;
        stray = 0;
        start_req(2'd0, 4'b0000);
        @(negedge clk);
        bus.req = 1'b0;
        bus.rand_in = 5'b00010;
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL rstsample_state busy=%b valid=%b exp 0 0", bus.busy, bus.valid); end
        checks++; if (bus.dir !== 2'd0 || bus.forced !== 1'b0) begin errors++; $display("FAIL rstsample_out dir=%0d forced=%b exp dir=0 forced=0", bus.dir, bus.forced); end
        reset_n = 1'b1;
        bus.rand_in = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rstsample_stray got=%0d exp=0", stray); end
    endtask

    // req held high: re-accepted in the IDLE cycle after DONE, latching the new cur_dir
    task automatic test_back_to_back();
        start_req(2'd0, 4'b0000);
        @(negedge clk);
        bus.rand_in = 5'b00001;
        bus.cur_dir = 2'd3;
        @(negedge clk);
        checks++; if (bus.valid !== 1'b1 || bus.dir !== 2'd1) begin errors++; $display("FAIL b2b_first valid=%b dir=%0d exp valid=1 dir=1", bus.valid, bus.dir); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b valid=%b exp 0 0", bus.busy, bus.valid); end
        @(negedge clk);
        bus.req = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got=%b exp=1", bus.busy); end
        bus.rand_in = 5'b10011;
        @(negedge clk);
        checks++; if (bus.valid !== 1'b1 || bus.dir !== 2'd3 || bus.forced !== 1'b0) begin errors++; $display("FAIL b2b_second valid=%b dir=%0d forced=%b exp 1 3 0", bus.valid, bus.dir, bus.forced); end
        @(negedge clk);
    endtask

    // req raised only during DONE is dropped
    task automatic test_req_in_done();
        start_req(2'd0, 4'b0000);
        @(negedge clk);
        bus.req = 1'b0;
        bus.rand_in = 5'b00001;
        @(negedge clk);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL reqdone_valid got=%b exp=1", bus.valid); end
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reqdone_idle got=%b exp=0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL reqdone_ignored busy=%b valid=%b exp 0 0", bus.busy, bus.valid); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        bus.req = 1'b0; bus.cur_dir = 2'd0; bus.blocked = 4'd0; bus.rand_in = '0;
        @(negedge clk);
        test_reset();
        test_direct_accept();
        test_reject_reverse();
        test_fallback_reverse();
        test_fallback_hold();
        test_reset_in_sample();
        test_max_tries();
        test_back_to_back();
        test_req_in_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
